// File: rtl/mem_access_unit_pkg.sv
// mem_access_pkg: size codes, FSM state type and byte-lane helpers shared by
// the load/store unit and its alignment datapath.
package mem_access_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Byte lanes touched by an access; size 2'b11 behaves as a word.
  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [1:0] size,
                                                     input logic [1:0] lo);
    logic [NUM_LANES-1:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << lo;
      SZ_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Half on an odd byte, or word not on a word boundary.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lo);
    logic r;
    case (size)
      SZ_BYTE: r = 1'b0;
      SZ_HALF: r = lo[0];
      default: r = |lo;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
// slave = the unit itself, master = whoever drives the core side and
// models the memory.
interface mem_access_unit_if #(parameter int ADDR_W = 32);
  logic              req_i;
  logic              we_i;
  logic [1:0]        size_i;
  logic              unsigned_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic [31:0]       rdata_o;
  logic              done_o;
  logic              busy_o;
  logic              err_o;
  logic              mem_rd_en_o;
  logic              mem_wr_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;
  logic [31:0]       mem_data_i;
  logic              mem_ack_i;

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, mem_data_i, mem_ack_i,
    output rdata_o, done_o, busy_o, err_o, mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o
  );

  modport master (
    output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, mem_data_i, mem_ack_i,
    input  rdata_o, done_o, busy_o, err_o, mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/mem_access_unit_lsu_align.sv
// lsu_align: combinational little-endian lane steering. Extracts and
// extends load data from a memory word, and merges store data into the
// previously read word so only the addressed lanes change.
module lsu_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);

  logic [NUM_LANES-1:0] mask;
  logic [31:0]          rep;
  logic [31:0]          shifted;
  logic [1:0]           sel;
  logic                 sbit;

  assign mask = lane_mask(size_i, addr_lo_i);

  // Replicate store data across lanes, pick the starting lane for loads.
  always_comb begin
    rep = wdata_i;
    sel = 2'b00;
    case (size_i)
      SZ_BYTE: begin rep = {4{wdata_i[7:0]}};  sel = addr_lo_i;           end
      SZ_HALF: begin rep = {2{wdata_i[15:0]}}; sel = {addr_lo_i[1], 1'b0}; end
      default: begin rep = wdata_i;            sel = 2'b00;                end
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign merged_o[8*g +: 8] = mask[g] ? rep[8*g +: 8] : word_i[8*g +: 8];
  end

  assign shifted = word_i >> {sel, 3'b000};

  // Sign or zero extension of the selected lanes.
  always_comb begin
    sbit    = 1'b0;
    rdata_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        sbit    = ~unsigned_i & shifted[7];
        rdata_o = {{24{sbit}}, shifted[7:0]};
      end
      SZ_HALF: begin
        sbit    = ~unsigned_i & shifted[15];
        rdata_o = {{16{sbit}}, shifted[15:0]};
      end
      default: rdata_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit turning byte/half/word accesses into
// word-aligned memory transactions; sub-word stores are read-modify-write.
// Build option MISALIGN_TRAP_EN: misaligned half/word accesses complete
// immediately with err_o instead of silently ignoring the low address bits.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  state_e            state_q, state_d;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, data_q, rdata_q;
  logic [31:0]       ld_val, st_word;
  logic              misalign;

  lsu_align u_align (
    .word_i    (bus.mem_data_i),
    .wdata_i   (wdata_q),
    .addr_lo_i (addr_q[1:0]),
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .rdata_o   (ld_val),
    .merged_o  (st_word)
  );

`ifdef MISALIGN_TRAP_EN
  logic err_q;
  assign misalign = is_misaligned(bus.size_i, bus.addr_i[1:0]);

  // Remember whether the access now completing was a trapped one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               err_q <= 1'b0;
    else if (state_q == ST_IDLE && bus.req_i) err_q <= misalign;
  end
  assign bus.err_o = err_q & (state_q == ST_DONE);
`else
  assign misalign  = 1'b0;
  assign bus.err_o = 1'b0;
`endif

  // Next-state: word stores skip the read; everything else waits on ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.req_i) begin
                  if (misalign)                      state_d = ST_DONE;
                  else if (bus.we_i && bus.size_i[1]) state_d = ST_WRITE;
                  else                               state_d = ST_READ;
                end
      ST_READ:  if (bus.mem_ack_i) state_d = we_q ? ST_WRITE : ST_DONE;
      ST_WRITE: if (bus.mem_ack_i) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, request capture, merged write word and load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && bus.req_i) begin
        we_q    <= bus.we_i;
        uns_q   <= bus.unsigned_i;
        size_q  <= bus.size_i;
        addr_q  <= bus.addr_i;
        wdata_q <= bus.wdata_i;
        data_q  <= bus.wdata_i;
      end
      if (state_q == ST_READ && bus.mem_ack_i) begin
        if (we_q) data_q  <= st_word;
        else      rdata_q <= ld_val;
      end
    end
  end

  assign bus.rdata_o     = rdata_q;
  assign bus.done_o      = (state_q == ST_DONE);
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.mem_rd_en_o = (state_q == ST_READ);
  assign bus.mem_wr_en_o = (state_q == ST_WRITE);
  assign bus.mem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_data_o  = data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory with programmable wait states and a
// byte-array reference model of memory contents and load results.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(32)) bus();
  mem_access_unit #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Memory as seen by the DUT (only writer is the always block below).
  logic [31:0] mem [0:63];
  int          wait_cfg = 0;
  int          wcnt = 0;
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  assign bus.mem_data_i = mem[bus.mem_addr_o[7:2]];
  assign bus.mem_ack_i  = (bus.mem_rd_en_o || bus.mem_wr_en_o) && (wcnt == 0);

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    if (bus.mem_wr_en_o && bus.mem_ack_i) mem[bus.mem_addr_o[7:2]] <= bus.mem_data_o;
    if (!(bus.mem_rd_en_o || bus.mem_wr_en_o) || bus.mem_ack_i) wcnt <= wait_cfg;
    else wcnt <= wcnt - 1;
  end

  // Reference model: byte-addressed memory.
  logic [7:0]  ref_b [0:255];
  logic [31:0] last_rd = '0;
  int errs = 0, checks = 0;

  int          o_lat;
  logic [31:0] o_rdata, o_wdata, o_waddr;
  logic        o_err;
  bit          o_rd, o_wr, o_both, o_unstable, o_en_done;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit misaligned(input logic [1:0] sz, input int a);
`ifdef MISALIGN_TRAP_EN
    return (a % nbytes(sz)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input int a);
    int n = nbytes(sz);
    int base = a - (a % n);
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_b[base+i]) << (8*i);
    if (!uns && n < 4 && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [1:0] sz, input int a, input logic [31:0] wd);
    int n = nbytes(sz);
    int base = a - (a % n);
    for (int i = 0; i < n; i++) ref_b[base+i] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
  endfunction

  function automatic int exp_lat(input logic we, input logic [1:0] sz, input int a, input int w);
    if (misaligned(sz, a)) return 1;
    if (!we || nbytes(sz) == 4) return 2 + w;
    return 3 + 2*w;
  endfunction

  task automatic preload(input int idx, input logic [31:0] v);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx[5:0]; pre_val = v;
    @(posedge clk); #1;
    pre_en = 1'b0;
    for (int i = 0; i < 4; i++) ref_b[4*idx+i] = v[8*i +: 8];
  endtask

  // Drive one request, hold it until done_o, and record what the bus did.
  task automatic do_access(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int w, input bit scramble);
    logic [31:0] a0, d0;
    bit have_a, have_d;
    wait_cfg = w;
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = we; bus.size_i = sz; bus.unsigned_i = uns;
    bus.addr_i = a; bus.wdata_i = wd;
    @(posedge clk);
    o_lat = -1; o_rd = 0; o_wr = 0; o_both = 0; o_unstable = 0; o_en_done = 0;
    o_err = 1'b0; o_wdata = '0; o_waddr = '0; have_a = 0; have_d = 0; a0 = '0; d0 = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.mem_rd_en_o && bus.mem_wr_en_o) o_both = 1;
      if (bus.mem_rd_en_o || bus.mem_wr_en_o) begin
        if (!have_a) begin have_a = 1; a0 = bus.mem_addr_o; end
        else if (bus.mem_addr_o !== a0) o_unstable = 1;
      end
      if (bus.mem_rd_en_o) o_rd = 1;
      if (bus.mem_wr_en_o) begin
        o_wr = 1; o_waddr = bus.mem_addr_o; o_wdata = bus.mem_data_o;
        if (!have_d) begin have_d = 1; d0 = bus.mem_data_o; end
        else if (bus.mem_data_o !== d0) o_unstable = 1;
      end
      if (bus.done_o) begin
        o_lat = c; o_err = bus.err_o; o_en_done = bus.mem_rd_en_o || bus.mem_wr_en_o;
        break;
      end
      if (scramble) begin
        bus.addr_i = $urandom; bus.we_i = 1'($urandom_range(0, 1));
        bus.size_i = 2'($urandom_range(0, 3)); bus.wdata_i = $urandom;
      end
    end
    o_rdata = bus.rdata_o;
    bus.req_i = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset;
    bus.req_i = 0; bus.we_i = 0; bus.size_i = 0; bus.unsigned_i = 0;
    bus.addr_i = '0; bus.wdata_i = '0;
    rst = 1'b1;
    #2;
    checks++;
    if (bus.rdata_o !== 32'h0) begin errs++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata_o); end
    checks++;
    if ({bus.done_o, bus.busy_o, bus.err_o, bus.mem_rd_en_o, bus.mem_wr_en_o} !== 5'b0) begin
      errs++; $display("FAIL reset_ctrl: got %b expected 00000",
        {bus.done_o, bus.busy_o, bus.err_o, bus.mem_rd_en_o, bus.mem_wr_en_o});
    end
    checks++;
    if ({bus.mem_addr_o, bus.mem_data_o} !== 64'h0) begin
      errs++; $display("FAIL reset_membus: got %h/%h expected 0/0", bus.mem_addr_o, bus.mem_data_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 64; i++) preload(i, $urandom);
  endtask

  task automatic test_word_roundtrip;
    do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, 0);
    ref_store(2'b10, 32'h10, 32'hDEADBEEF);
    checks++;
    if (o_lat != 2) begin errs++; $display("FAIL sw_latency: got %0d expected 2", o_lat); end
    checks++;
    if (!(o_wr && !o_rd) || o_waddr !== 32'h10 || o_wdata !== 32'hDEADBEEF) begin
      errs++; $display("FAIL sw_bus: got wr=%0d rd=%0d addr=%h data=%h expected wr=1 rd=0 addr=00000010 data=deadbeef",
        o_wr, o_rd, o_waddr, o_wdata);
    end
    checks++;
    if (o_rdata !== last_rd) begin errs++; $display("FAIL sw_rdata_hold: got %h expected %h", o_rdata, last_rd); end
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 0);
    last_rd = 32'hDEADBEEF;
    checks++;
    if (o_lat != 2) begin errs++; $display("FAIL lw_latency: got %0d expected 2", o_lat); end
    checks++;
    if (o_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL lw_rdata: got %h expected deadbeef", o_rdata); end
  endtask

  task automatic test_byte_merge;
    preload(8, 32'h11223344);
    do_access(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA, 0, 0);
    ref_store(2'b00, 32'h22, 32'hAA);
    checks++;
    if (o_lat != 3) begin errs++; $display("FAIL sb_latency: got %0d expected 3", o_lat); end
    checks++;
    if (!(o_rd && o_wr) || o_wdata !== 32'h11AA3344) begin
      errs++; $display("FAIL sb_merge: got rd=%0d wr=%0d data=%h expected rd=1 wr=1 data=11aa3344", o_rd, o_wr, o_wdata);
    end
    checks++;
    if (mem[8] !== 32'h11AA3344) begin errs++; $display("FAIL sb_mem: got %h expected 11aa3344", mem[8]); end
  endtask

  task automatic test_load_ext;
    logic [1:0]  szs [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        uns [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] adr [4] = '{32'h3, 32'h3, 32'h0, 32'h2};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'hFFFF80FF};
    preload(0, 32'h80FF7F01);
    for (int i = 0; i < 4; i++) begin
      do_access(1'b0, szs[i], uns[i], adr[i], 32'h0, 0, 0);
      last_rd = exp[i];
      checks++;
      if (o_rdata !== exp[i] || o_lat != 2) begin
        errs++; $display("FAIL load_ext[%0d]: got %h lat %0d expected %h lat 2", i, o_rdata, o_lat, exp[i]);
      end
    end
  endtask

  task automatic test_wait_states;
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 1);
    last_rd = 32'hDEADBEEF;
    checks++;
    if (o_lat != 5) begin errs++; $display("FAIL wait_latency: got %0d expected 5", o_lat); end
    checks++;
    if (o_unstable || o_both) begin errs++; $display("FAIL wait_stable: got unstable=%0d both=%0d expected 0/0", o_unstable, o_both); end
    checks++;
    if (o_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL wait_rdata: got %h expected deadbeef", o_rdata); end
    do_access(1'b1, 2'b01, 1'b0, 32'h12, 32'hCAFE5566, 2, 1);
    ref_store(2'b01, 32'h12, 32'hCAFE5566);
    checks++;
    if (o_lat != 7 || o_unstable || o_wdata !== ref_word(4)) begin
      errs++; $display("FAIL wait_sh: got lat=%0d unstable=%0d data=%h expected lat=7 unstable=0 data=%h",
        o_lat, o_unstable, o_wdata, ref_word(4));
    end
  endtask

  task automatic test_reset_mid_store;
    bit seen_wr = 0, seen_done = 0;
    preload(16, 32'hCAFEF00D);
    wait_cfg = 2;
    @(negedge clk);
    bus.req_i = 1; bus.we_i = 1; bus.size_i = 2'b01; bus.unsigned_i = 0;
    bus.addr_i = 32'h42; bus.wdata_i = 32'h1234;
    for (int c = 0; c < 20 && !seen_wr; c++) begin
      @(negedge clk);
      if (bus.mem_wr_en_o) seen_wr = 1;
    end
    checks++;
    if (!seen_wr) begin errs++; $display("FAIL rst_store_reach_write: got no write expected write"); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_wr_en_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.mem_rd_en_o !== 1'b0) begin
      errs++; $display("FAIL rst_async_drop: got wr=%b rd=%b busy=%b expected 0/0/0",
        bus.mem_wr_en_o, bus.mem_rd_en_o, bus.busy_o);
    end
    bus.req_i = 0;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    last_rd = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.done_o) seen_done = 1;
    end
    checks++;
    if (seen_done || mem[16] !== 32'hCAFEF00D) begin
      errs++; $display("FAIL rst_store_effect: got done=%0d mem=%h expected done=0 mem=cafef00d", seen_done, mem[16]);
    end
  endtask

  task automatic test_misalign;
    preload(1, 32'h0BADF00D);
    do_access(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 0, 0);
`ifdef MISALIGN_TRAP_EN
    checks++;
    if (o_lat != 1 || o_err !== 1'b1 || o_rd || o_wr || o_rdata !== last_rd) begin
      errs++; $display("FAIL misalign_trap: got lat=%0d err=%b rd=%0d wr=%0d rdata=%h expected 1/1/0/0/%h",
        o_lat, o_err, o_rd, o_wr, o_rdata, last_rd);
    end
`else
    last_rd = 32'h0BADF00D;
    checks++;
    if (o_lat != 2 || o_err !== 1'b0 || o_rdata !== 32'h0BADF00D) begin
      errs++; $display("FAIL misalign_ignore: got lat=%0d err=%b rdata=%h expected 2/0/0badf00d",
        o_lat, o_err, o_rdata);
    end
`endif
  endtask

  task automatic test_random;
    int bad = 0;
    for (int n = 0; n < 40; n++) begin
      logic        we  = 1'($urandom_range(0, 1));
      logic [1:0]  sz  = 2'($urandom_range(0, 3));
      logic        uns = 1'($urandom_range(0, 1));
      int          a   = $urandom_range(0, 255);
      logic [31:0] wd  = $urandom;
      int          w   = $urandom_range(0, 2);
      bit          mis = misaligned(sz, a);
      int          el  = exp_lat(we, sz, a, w);
      if (!we && !mis) last_rd = ref_load(sz, uns, a);
      if (we && !mis) ref_store(sz, a, wd);
      do_access(we, sz, uns, a, wd, w, 1'($urandom_range(0, 1)));
      checks++;
      if (o_lat != el) begin errs++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, o_lat, el); end
      checks++;
      if (o_err !== mis) begin errs++; $display("FAIL rand_err[%0d]: got %b expected %b", n, o_err, mis); end
      checks++;
      if (o_rdata !== last_rd) begin errs++; $display("FAIL rand_rdata[%0d]: got %h expected %h", n, o_rdata, last_rd); end
      checks++;
      if (o_both || o_en_done || o_unstable || (mis && (o_rd || o_wr))) begin
        errs++; $display("FAIL rand_protocol[%0d]: got both=%0d en_in_done=%0d unstable=%0d rd=%0d wr=%0d expected clean",
          n, o_both, o_en_done, o_unstable, o_rd, o_wr);
      end
    end
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_word(i)) bad++;
    checks++;
    if (bad != 0) begin errs++; $display("FAIL final_memory: got %0d differing words expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_word_roundtrip();
    test_byte_merge();
    test_load_ext();
    test_wait_states();
    test_reset_mid_store();
    test_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit between the processor core's data port and the word-organised `Memory`. It turns byte, halfword and word loads and stores into word-aligned memory transactions. Loads are extracted little-endian and sign- or zero-extended. Sub-word stores become a read-modify-write so the memory only ever sees full-word writes.

## Interface
Parameters:
- `ADDR_W`, 32: address width on both sides.

Ports (core side, then memory side):
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_i`  in  1: access request; sampled only in IDLE.
- `we_i`  in  1: 1 = store, 0 = load.
- `size_i`  in  2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `unsigned_i`  in  1: load zero-extends when 1, sign-extends when 0.
- `addr_i`  in  ADDR_W: byte address.
- `wdata_i`  in  32: store data, right-aligned.
- `rdata_o`  out  32: formatted load result, registered.
- `done_o`  out  1: one-cycle completion pulse.
- `busy_o`  out  1: high whenever state ≠ IDLE.
- `err_o`  out  1: misaligned-access flag, pulses with `done_o`.
- `mem_rd_en_o`  out  1: memory read enable.
- `mem_wr_en_o`  out  1: memory write enable.
- `mem_addr_o`  out  ADDR_W: word-aligned address, `{addr[ADDR_W-1:2],2'b00}`.
- `mem_data_o`  out  32: full write word.
- `mem_data_i`  in  32: memory read data, combinational from the memory.
- `mem_ack_i`  in  1: memory transaction acknowledge.

## Operation
States: IDLE, READ, WRITE, DONE.
- **Request capture.** In IDLE with `req_i`=1, the unit latches `we`, `size`, `unsigned`, `addr` and `wdata`.
- **IDLE exit.** A load or a sub-word store goes to READ. A word store goes to WRITE, with `mem_data_o = wdata`.
- **READ.** `mem_rd_en_o`=1. The unit waits for `mem_ack_i`. On ack it samples `mem_data_i`.
  - Load: `rdata_o` gets the extracted, extended value; go to DONE.
  - Store: build the merged word, go to WRITE.
- **Merge.** Only the addressed lanes are replaced; all other lanes keep the read data.
  - Byte: lane `addr[1:0]`.
  - Half: lanes `{addr[1],0}` and `{addr[1],1}`.
- **WRITE.** `mem_wr_en_o`=1 and `mem_data_o` = merged word. On `mem_ack_i`, go to DONE.
- **DONE.** `done_o`=1 for exactly one cycle, then IDLE.
- **Request acceptance.** `req_i` is ignored outside IDLE. The core must hold its request until `done_o`; a request present in the cycle `done_o` is high is not accepted.
- **Enables.** `mem_rd_en_o` and `mem_wr_en_o` are never both high. Both are low in IDLE and DONE.
- **Load extraction.**
  - Byte: lane `addr[1:0]`, bits [7:0].
  - Half: lanes selected by `addr[1]`, bits [15:0].
  - Extension: bit 7 or bit 15 is replicated when `unsigned`=0.
- **`rdata_o` hold.** `rdata_o` changes only on load completion and holds between loads.

## Timing
- **Reset values.** Every output and every register resets to 0; state resets to IDLE.
- **Reset mid-operation.** Asserting `rst` in any state forces IDLE at once and drops the memory enables with no clock edge. No partial write is issued after reset.
- **Latency** (request accepted at edge 0, zero-wait memory, `mem_ack_i` high in the same cycle as the enable):
  - Load: `done_o` at cycle 2.
  - Word store: `done_o` at cycle 2.
  - Sub-word store: `done_o` at cycle 3.
- **Wait states.** Each cycle with `mem_ack_i`=0 adds one cycle. Address, data and enables stay stable while waiting.
- **`busy_o`** is high from the cycle after acceptance through DONE inclusive.

## Configuration
- **`MISALIGN_TRAP_EN` defined.**
  - An access is misaligned when it is a half with `addr[0]`=1, or a word with `addr[1:0]`≠0.
  - It goes IDLE → DONE directly, with no memory enable asserted.
  - `err_o`=1 together with `done_o`; `rdata_o` is unchanged.
- **`MISALIGN_TRAP_EN` undefined.**
  - Low address bits below the access size are ignored: half uses `addr[1]` only, word uses no low bits.
  - `err_o` is tied to 0.

## Structure
- **Package `mem_access_pkg`.**
  - Size codes: `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - State enum: `ST_IDLE`, `ST_READ`, `ST_WRITE`, `ST_DONE`.
  - Byte-lane mask function.
- **Sub-module `lsu_align`.** Purely combinational; the top holds only the FSM and registers.
  - Load extraction and extension: `(word, addr[1:0], size, unsigned) → rdata`.
  - Store merge: `(old word, wdata, addr[1:0], size) → new word`.

## Test plan
- **Word round trip.** SW 0xDEADBEEF to 0x10, then LW 0x10 → `mem_wr_en_o` pulse at cycle 1 with `mem_addr_o`=0x10; `rdata_o`=0xDEADBEEF; `done_o` at cycle 2 for each.
- **Byte store merge.** Memory word at 0x20 = 0x11223344; SB 0xAA to 0x22 → READ then WRITE with `mem_data_o`=0x11AA3344; `done_o` at cycle 3.
- **Load extension.** Word = 0x80FF7F01:
  - LB 0x03 → 0xFFFFFF80.
  - LBU 0x03 → 0x00000080.
  - LH 0x00 → 0x00007F01.
  - LH 0x02 → 0xFFFF80FF.
- **Wait states.** `mem_ack_i` held low 3 cycles during READ of an LW → enables and address stable; `done_o` at cycle 5; requests arriving while `busy_o`=1 are ignored.
- **Reset mid-store.** `rst` asserted during WRITE → `mem_wr_en_o` drops in the same cycle; memory unchanged; state IDLE; `done_o` never pulses.
- **Misaligned access.**
  - With `MISALIGN_TRAP_EN`: LW to 0x06 → `err_o`=`done_o`=1 at cycle 1, no memory enable.
  - Without: same access reads word 0x04.
